// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch front-end state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [0:0] {FETCH = 1'b0, DRAIN = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count; head is read combinationally
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  always_comb begin
    push_ok = push && cnt_q != (AW+1)'(DEPTH);
    pop_ok = pop && cnt_q != '0;
    wr_d = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d = pop_ok ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential-PC fetch front end with instruction queue, redirect flush and stale-response drain
module fetch_unit import riscv_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] initial_address,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [XLEN-1:0] de_instruction,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_plus4
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, tag_pc;
  logic [CW-1:0] outst_q, outst_d, q_count, t_count;
  logic [2*XLEN-1:0] head;
  logic issue, resp, accept, pop;
  always_comb begin
    imem_req = !reset && !redirect_valid && state_q == FETCH &&
               ({1'b0, q_count} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
    issue = imem_req && imem_gnt;
    resp = imem_rvalid && outst_q != '0;
    accept = resp && state_q == FETCH && !redirect_valid;
    pop = de_valid && de_ready && !redirect_valid;
    outst_d = outst_q + CW'(issue) - CW'(resp);
    pc_d = redirect_valid ? redirect_addr & ~XLEN'(3) : issue ? pc_q + XLEN'(4) : pc_q;
    state_d = (redirect_valid || state_q == DRAIN) ? (outst_d == '0 ? FETCH : DRAIN) : FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= initial_address & ~XLEN'(3);
      outst_q <= '0;
      state_q <= FETCH;
    end else begin
      pc_q <= pc_d;
      outst_q <= outst_d;
      state_q <= state_d;
    end
  end
  // tag FIFO pairs each in-order response with the PC it was fetched from
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tags (
    .clk(clk), .reset(reset), .flush(redirect_valid), .push(issue), .pop(accept),
    .wdata(pc_q), .rdata(tag_pc), .count(t_count)
  );
  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .reset(reset), .flush(redirect_valid), .push(accept), .pop(pop),
    .wdata({tag_pc, imem_rdata}), .rdata(head), .count(q_count)
  );
  assign imem_addr = pc_q;
  assign de_valid = !reset && q_count != '0;
  assign de_pc = head[2*XLEN-1:XLEN];
  assign de_instruction = head[XLEN-1:0];
  assign de_pc_plus4 = de_pc + XLEN'(4);
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rvalid && outst_q == '0));
      assert (state_q == DRAIN || t_count == outst_q);
    end
  end
endmodule
